// File: rtl/mem_align_unit_pkg.sv
// Shared width encodings, FSM state type and default window base for mem_align_unit.
// The ACC1 state exists only when MEM_ALIGN_SPLIT_EN is defined.
package mem_align_unit_pkg;

    localparam logic [1:0]  WIDTH_B = 2'b00;
    localparam logic [1:0]  WIDTH_H = 2'b01;
    localparam logic [1:0]  WIDTH_W = 2'b10;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_1000;

`ifdef MEM_ALIGN_SPLIT_EN
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc0 = 2'd1,
        StAcc1 = 2'd2,
        StResp = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc0 = 2'd1,
        StResp = 2'd3
    } state_e;
`endif

    // Lanes touched by an access: [3:0] in the first word, [7:4] in the following word.
    function automatic logic [7:0] span_mask(input logic [1:0] width, input logic [1:0] lo);
        logic [7:0] base;
        case (width)
            WIDTH_B: base = 8'h01;
            WIDTH_H: base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << lo;
    endfunction

endpackage

// File: rtl/mem_lane_rotate.sv
// Combinational byte rotator: rotates a 32-bit word left by amt_i byte lanes.
module mem_lane_rotate (
    input  logic [31:0] data_i,
    input  logic [1:0]  amt_i,
    output logic [31:0] data_o
);

    always_comb begin
        case (amt_i)
            2'd0:    data_o = data_i;
            2'd1:    data_o = {data_i[23:0], data_i[31:24]};
            2'd2:    data_o = {data_i[15:0], data_i[31:16]};
            default: data_o = {data_i[7:0],  data_i[31:8]};
        endcase
    end

endmodule

// File: rtl/mem_align_unit.sv
// Byte-lane load/store alignment unit in front of four 8-bit lane RAMs.
// MEM_ALIGN_SPLIT_EN enables word-crossing accesses; otherwise misaligned accesses are rejected.
module mem_align_unit
    import mem_align_unit_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned LANE_AW   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [1:0]         req_width,
    input  logic               req_sign,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    output logic               rsp_err,
    output logic [31:0]        rsp_rdata,
    output logic               mem_re,
    output logic [3:0]         mem_we,
    output logic [LANE_AW-1:0] mem_addr0,
    output logic [LANE_AW-1:0] mem_addr1,
    output logic [LANE_AW-1:0] mem_addr2,
    output logic [LANE_AW-1:0] mem_addr3,
    output logic [7:0]         mem_wdata0,
    output logic [7:0]         mem_wdata1,
    output logic [7:0]         mem_wdata2,
    output logic [7:0]         mem_wdata3,
    input  logic [7:0]         mem_rdata0,
    input  logic [7:0]         mem_rdata1,
    input  logic [7:0]         mem_rdata2,
    input  logic [7:0]         mem_rdata3
);

    localparam logic [32:0] WinBytes = 33'(4) << LANE_AW;

    state_e             state_q;
    logic               ready_q, valid_q, err_q, re_q;
    logic [3:0]         we_mask_q;
    logic [LANE_AW-1:0] addr_q;
    logic [31:0]        wdata_q;
    logic               is_store_q, sign_q;
    logic [1:0]         width_q, lo_q;
`ifdef MEM_ALIGN_SPLIT_EN
    logic [3:0]         next_mask_q;
    logic [31:0]        buf_q;
`endif

    logic [31:0] req_off, store_rot, live, merged, load_rot, load_ext;
    logic [1:0]  sz_m1, load_amt;
    logic [32:0] req_last;
    logic [7:0]  req_span;
    logic        req_reject;

    always_comb begin
        req_off = req_addr - BASE_ADDR;
        case (req_width)
            WIDTH_B: sz_m1 = 2'd0;
            WIDTH_H: sz_m1 = 2'd1;
            default: sz_m1 = 2'd3;
        endcase
        req_last   = {1'b0, req_off} + {31'b0, sz_m1};
        req_span   = span_mask(req_width, req_off[1:0]);
        req_reject = (req_width == 2'b11) || ({1'b0, req_off} >= WinBytes) ||
                     (req_last >= WinBytes);
`ifndef MEM_ALIGN_SPLIT_EN
        req_reject = req_reject || ((req_off[1:0] & sz_m1) != 2'b00);
`endif
    end

`ifndef MEM_ALIGN_SPLIT_EN
    logic unused_span_hi;
    assign unused_span_hi = ^req_span[7:4];
`endif

    mem_lane_rotate u_store_rot (
        .data_i (req_wdata),
        .amt_i  (req_off[1:0]),
        .data_o (store_rot)
    );

    // Lanes served by the second word arrive live; first-word lanes come from buf_q.
    assign live = {mem_rdata3, mem_rdata2, mem_rdata1, mem_rdata0};
    always_comb begin
        merged = live;
`ifdef MEM_ALIGN_SPLIT_EN
        if (next_mask_q != 4'b0000) begin
            for (int i = 0; i < 4; i++) begin
                if (!next_mask_q[i]) merged[8*i +: 8] = buf_q[8*i +: 8];
            end
        end
`endif
    end

    assign load_amt = 2'd0 - lo_q;

    mem_lane_rotate u_load_rot (
        .data_i (merged),
        .amt_i  (load_amt),
        .data_o (load_rot)
    );

    always_comb begin
        case (width_q)
            WIDTH_B: load_ext = {{24{sign_q & load_rot[7]}},  load_rot[7:0]};
            WIDTH_H: load_ext = {{16{sign_q & load_rot[15]}}, load_rot[15:0]};
            default: load_ext = load_rot;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            re_q       <= 1'b0;
            we_mask_q  <= 4'b0000;
            addr_q     <= '0;
            wdata_q    <= 32'b0;
            is_store_q <= 1'b0;
            sign_q     <= 1'b0;
            width_q    <= 2'b00;
            lo_q       <= 2'b00;
`ifdef MEM_ALIGN_SPLIT_EN
            next_mask_q <= 4'b0000;
            buf_q       <= 32'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        ready_q    <= 1'b0;
                        is_store_q <= req_we;
                        sign_q     <= req_sign;
                        width_q    <= req_width;
                        lo_q       <= req_off[1:0];
`ifdef MEM_ALIGN_SPLIT_EN
                        next_mask_q <= req_span[7:4];
`endif
                        if (req_reject) begin
                            state_q <= StResp;
                            valid_q <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q   <= StAcc0;
                            addr_q    <= req_off[LANE_AW+1:2];
                            re_q      <= !req_we;
                            we_mask_q <= req_we ? req_span[3:0] : 4'b0000;
                            wdata_q   <= req_we ? store_rot : 32'b0;
                        end
                    end
                end
                StAcc0: begin
                    state_q   <= StResp;
                    valid_q   <= 1'b1;
                    re_q      <= 1'b0;
                    we_mask_q <= 4'b0000;
`ifdef MEM_ALIGN_SPLIT_EN
                    if (next_mask_q != 4'b0000) begin
                        state_q   <= StAcc1;
                        valid_q   <= 1'b0;
                        re_q      <= re_q;
                        addr_q    <= addr_q + LANE_AW'(1);
                        we_mask_q <= is_store_q ? next_mask_q : 4'b0000;
                    end
`endif
                end
`ifdef MEM_ALIGN_SPLIT_EN
                StAcc1: begin
                    state_q   <= StResp;
                    valid_q   <= 1'b1;
                    re_q      <= 1'b0;
                    we_mask_q <= 4'b0000;
                    buf_q     <= live;
                end
`endif
                StResp: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign rsp_valid  = valid_q;
    assign rsp_err    = err_q;
    assign rsp_rdata  = (state_q == StResp && !is_store_q && !err_q) ? load_ext : 32'b0;
    assign mem_re     = re_q;
    assign mem_we     = we_mask_q;
    assign mem_addr0  = addr_q;
    assign mem_addr1  = addr_q;
    assign mem_addr2  = addr_q;
    assign mem_addr3  = addr_q;
    assign mem_wdata0 = wdata_q[7:0];
    assign mem_wdata1 = wdata_q[15:8];
    assign mem_wdata2 = wdata_q[23:16];
    assign mem_wdata3 = wdata_q[31:24];

endmodule
